// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   Serializes parallel payload bytes onto an idle-high UART TX line. Bit
//   timing comes from the baud generator's baud_clk square wave. baud_clk is in
//   the same clock domain, so it is sampled directly. Each rising edge of
//   baud_clk (one clock wide, bit_tick) marks a bit period boundary.
//   Frame layout: start(0), DATA_BITS payload bits LSB first, an optional
//   parity bit, then one or two stop bits(1).
//
// Parameters:
//   DATA_BITS  payload bits per frame, legal range 5..8 (default 8)
//
// Ports:
//   clock       in   system clock, the only clock
//   reset       in   synchronous, active-high reset
//   baud_clk    in   registered baud square wave (same domain)
//   tx_valid    in   upstream has a frame to send
//   tx_data     in   payload, DATA_BITS wide
//   parity_en   in   1 = append a parity bit
//   parity_odd  in   1 = odd parity, 0 = even parity
//   two_stop    in   1 = two stop bits, 0 = one stop bit
//   tx_ready    out  frame accepted this cycle if tx_valid is high
//   tx          out  registered serial line
//   tx_busy     out  a frame is in flight
//   tx_done     out  one-cycle pulse when the final stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  // Payload is at most 8 bits, so a 3-bit index always suffices.
  localparam int               IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  // Control state (reset)
  state_t           state, state_n;
  logic             baud_d;
  logic [IDX_W-1:0] bit_idx, bit_idx_n;
  logic             stop_cnt, stop_cnt_n;
  logic             tx_n;
  logic             tx_busy_n;
  logic             tx_done_n;

  // Frame data latched at accept (not reset; only consulted mid-frame)
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 par_en_q, par_en_n;
  logic                 par_bit_q, par_bit_n;
  logic                 two_stop_q, two_stop_n;

  logic bit_tick;
  logic last_stop;
  logic accept;

  // Even parity makes the total count of ones even: the XOR of the data.
  // Odd parity is its complement.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d,
                                     input logic                 odd);
    return odd ? ~^d : ^d;
  endfunction

  // Rising-edge detect of the baud square wave; one clock wide.
  assign bit_tick = baud_clk & ~baud_d;

  // With two stop bits the first stop tick only advances stop_cnt.
  assign last_stop = ~(two_stop_q & (stop_cnt == 1'b0));

  // Ready in the final stop-tick cycle so a waiting frame follows with no
  // idle gap between its start bit and the previous stop bit.
  assign tx_ready = (state == IDLE) |
                    ((state == STOP) & last_stop & bit_tick);

  assign accept = tx_valid & tx_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud_d   <= 1'b0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_d   <= baud_clk;
      bit_idx  <= bit_idx_n;
      stop_cnt <= stop_cnt_n;
      tx       <= tx_n;
      tx_busy  <= tx_busy_n;
      tx_done  <= tx_done_n;
    end
  end

  always_ff @(posedge clock) begin
    shreg      <= shreg_n;
    par_en_q   <= par_en_n;
    par_bit_q  <= par_bit_n;
    two_stop_q <= two_stop_n;
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    bit_idx_n  = bit_idx;
    stop_cnt_n = stop_cnt;
    tx_n       = tx;
    tx_busy_n  = tx_busy;
    tx_done_n  = 1'b0;
    shreg_n    = shreg;
    par_en_n   = par_en_q;
    par_bit_n  = par_bit_q;
    two_stop_n = two_stop_q;

    // Accept only happens in IDLE or the last stop tick, so latching here
    // never collides with the DATA-state shift below.
    if (accept) begin
      shreg_n    = tx_data;
      par_en_n   = parity_en;
      par_bit_n  = parity_of(tx_data, parity_odd);
      two_stop_n = two_stop;
    end

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          state_n   = SYNC;
          tx_busy_n = 1'b1;
        end
      end

      // Waiting for a tick gives the start bit a full bit period.
      SYNC: begin
        if (bit_tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end

      START: begin
        if (bit_tick) begin
          tx_n      = shreg[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end

      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST_IDX) begin
            if (par_en_q) begin
              tx_n    = par_bit_q;
              state_n = PARITY;
            end else begin
              tx_n       = 1'b1;
              stop_cnt_n = 1'b0;
              state_n    = STOP;
            end
          end else begin
            // shreg[0] is on the line; shreg[1] becomes the next bit.
            shreg_n   = shreg >> 1;
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = shreg[1];
          end
        end
      end

      PARITY: begin
        if (bit_tick) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end

      STOP: begin
        if (bit_tick) begin
          if (!last_stop) begin
            stop_cnt_n = 1'b1;
          end else begin
            tx_done_n = 1'b1;
            if (accept) begin
              tx_n    = 1'b0;
              state_n = START;
            end else begin
              state_n   = IDLE;
              tx_busy_n = 1'b0;
            end
          end
        end
      end

      default: begin
        state_n   = IDLE;
        tx_n      = 1'b1;
        tx_busy_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Scoreboard bench for uart_tx_serializer. The stimulus process pushes the
// hand-computed bit sequence of every frame it issues (first character = first
// bit on the line) into a queue. The monitor process watches tx for a start
// bit, pops the next expected frame and checks every bit for exactly 8 clocks,
// tx_busy throughout, and the tx_done pulse at the end.
// baud_clk toggles every 4 clocks, so one bit period is 8 clocks.
// -----------------------------------------------------------------------------
module tb_uart_tx_serializer;

  logic       clock;
  logic       reset;
  logic       baud_clk;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  typedef struct {
    logic [11:0] bits;
    int          len;
    bit          b2b;
    logic [7:0]  data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  bit   mon_en   = 1'b1;
  bit   mon_busy = 1'b0;

  uart_tx_serializer #(.DATA_BITS(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .baud_clk   (baud_clk),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    baud_clk = 1'b0;
    forever begin
      repeat (4) @(posedge clock);
      #1 baud_clk = ~baud_clk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Called just after a negedge. Leaves tx_valid high when keep is set so a
  // following frame can be handed over back-to-back.
  task automatic send(input logic [7:0] d, input logic pe, input logic po,
                      input logic ts, input string pat, input bit b2b,
                      input bit push, input bit keep);
    exp_t e;
    bit   ok;
    if (push) begin
      e.bits = '0;
      e.len  = pat.len();
      for (int i = 0; i < e.len; i++) e.bits[i] = (pat[i] == 8'h31);
      e.b2b  = b2b;
      e.data = d;
      sb.push_back(e);
    end
    tx_valid   = 1'b1;
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (tx_ready === 1'b1) ok = 1'b1;
      @(negedge clock);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_%02h: tx_ready not seen, required accept within 400 cycles", d);
    end
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (sb.size() != 0 || mon_busy) begin
      errors++;
      $display("FAIL drain_%s: %0d frames outstanding, required 0", tag, sb.size());
    end
  endtask

  // Monitor: sample index k counts negedges from the first start-bit sample.
  initial begin : monitor
    exp_t e;
    bit   carry;
    bit   bad;
    logic a_tx, a_busy, a_done;
    int   n;
    carry = 1'b0;
    forever begin
      if (!carry) begin
        do @(negedge clock); while (!(mon_en && tx === 1'b0));
      end
      carry    = 1'b0;
      mon_busy = 1'b1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: start bit seen with tx_busy=%b, required no frame", tx_busy);
        n = 0;
        while (!(tx === 1'b1 && tx_busy === 1'b0) && n < 200) begin
          @(negedge clock);
          n++;
        end
        mon_busy = 1'b0;
        continue;
      end
      e = sb.pop_front();
      for (int j = 0; j < e.len; j++) begin
        bad = 1'b0;
        a_tx = 1'b0; a_busy = 1'b0; a_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
          if (!(j == 0 && c == 0)) @(negedge clock);
          if (!bad && (tx !== e.bits[j] || tx_busy !== 1'b1 ||
                       (!(j == 0 && c == 0) && tx_done !== 1'b0))) begin
            bad = 1'b1;
            a_tx = tx; a_busy = tx_busy; a_done = tx_done;
          end
        end
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL frame_%02h_bit%0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0 for 8 clocks",
                   e.data, j, a_tx, a_busy, a_done, e.bits[j]);
        end
      end
      @(negedge clock);
      chk($sformatf("done_%02h", e.data), tx_done, 1'b1);
      if (e.b2b) begin
        chk($sformatf("b2b_start_%02h", e.data), tx, 1'b0);
        chk($sformatf("b2b_busy_%02h", e.data), tx_busy, 1'b1);
        carry = 1'b1;
      end else begin
        chk($sformatf("end_busy_%02h", e.data), tx_busy, 1'b0);
        chk($sformatf("end_ready_%02h", e.data), tx_ready, 1'b1);
        @(negedge clock);
        chk($sformatf("done_pulse_%02h", e.data), tx_done, 1'b0);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    bit bad;
    int n;
    reset      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", tx_busy, 1'b0);
    chk("reset_done", tx_done, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", tx_ready, 1'b1);
    repeat (5) @(negedge clock);

    // 0x55, no parity, one stop
    send(8'h55, 1'b0, 1'b0, 1'b0, "0101010101", 1'b0, 1'b1, 1'b0);
    drain("55");
    repeat (3) @(negedge clock);

    // 0xA3 even then odd parity
    send(8'hA3, 1'b1, 1'b0, 1'b0, "01100010101", 1'b0, 1'b1, 1'b0);
    drain("a3_even");
    send(8'hA3, 1'b1, 1'b1, 1'b0, "01100010111", 1'b0, 1'b1, 1'b0);
    drain("a3_odd");

    // 0x07 odd parity, two stop bits
    send(8'h07, 1'b1, 1'b1, 1'b1, "011100000011", 1'b0, 1'b1, 1'b0);
    drain("07");

    // Back-to-back 0x12 then 0x34 with tx_valid held high
    send(8'h12, 1'b0, 1'b0, 1'b0, "0010010001", 1'b1, 1'b1, 1'b1);
    send(8'h34, 1'b0, 1'b0, 1'b0, "0001011001", 1'b0, 1'b1, 1'b0);
    drain("b2b");
    repeat (3) @(negedge clock);

    // Inputs change mid-frame and tx_valid pulses while busy
    send(8'h3C, 1'b1, 1'b0, 1'b0, "00011110001", 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clock);
    tx_data    = 8'hFF;
    parity_en  = 1'b0;
    parity_odd = 1'b1;
    two_stop   = 1'b1;
    repeat (15) @(negedge clock);
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (10) @(negedge clock);
    tx_valid = 1'b1;
    repeat (3) @(negedge clock);
    tx_valid = 1'b0;
    drain("3c");
    bad = 1'b0;
    repeat (60) begin
      @(negedge clock);
      if (tx_busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk("no_extra_accept", bad, 1'b0);
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;

    // Reset during data bit 3 of an unchecked frame
    mon_en = 1'b0;
    send(8'hA5, 1'b0, 1'b0, 1'b0, "", 1'b0, 1'b0, 1'b0);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("rst_frame_start", tx, 1'b0);
    repeat (35) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", tx_busy, 1'b0);
    chk("rst_mid_ready", tx_ready, 1'b1);
    chk("rst_mid_done", tx_done, 1'b0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
    end
    chk("rst_abandoned", bad, 1'b0);
    mon_en = 1'b1;
    send(8'hFF, 1'b0, 1'b0, 1'b0, "0111111111", 1'b0, 1'b1, 1'b0);
    drain("ff");
    repeat (5) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Serializes parallel bytes onto the UART TX line.
- Sits directly downstream of the TX baud generator and consumes its baud_clk square wave.
- Each rising edge of baud_clk marks one bit period.
- Upstream logic hands over frames through a valid/ready handshake. The serial line stays idle-high between frames.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first; legal range 5..8.

Ports:
- clock  in  1  system clock; the only clock; baud_clk is sampled as data.
- reset  in  1  synchronous, active-high reset.
- baud_clk  in  1  square wave from the baud generator, same clock domain, registered.
- tx_valid  in  1  upstream has a frame to send.
- tx_data  in  DATA_BITS  payload.
- parity_en  in  1  1 = append a parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- two_stop  in  1  1 = two stop bits, 0 = one stop bit.
- tx_ready  out  1  block can accept a frame this cycle.
- tx  out  1  serial line, registered.
- tx_busy  out  1  a frame is in flight.
- tx_done  out  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high; clock port is named clock, reset port is named reset.
- Reset values: tx=1, tx_busy=0, tx_done=0, state=IDLE, baud_d=0, bit_idx=0, stop_cnt=0. tx_ready=1 in the cycle after reset deasserts.
- Tick: bit_tick = baud_clk & ~baud_d, where baud_d is baud_clk delayed one clock. No synchronizer is used (same domain).
  - A tick in IDLE or SYNC-less states is ignored.
  - A spurious tick right after reset is harmless because it arrives in IDLE.
- Handshake: accept occurs when tx_valid & tx_ready.
  - On accept, latch tx_data, parity_en, parity_odd and two_stop.
  - Input changes after accept have no effect on the current frame.
  - tx_valid is ignored while tx_ready=0.
- tx_ready = (state==IDLE) | (state==STOP & last stop bit & bit_tick). This is combinational from registered state and the tick.
- FSM; all transitions happen only on bit_tick except IDLE->SYNC:
  - IDLE: tx=1. On accept -> SYNC, tx_busy=1.
  - SYNC: wait for tick; on tick tx<=0 -> START. This aligns the start bit to a full period.
  - START: on tick tx<=shreg[0], bit_idx<=0 -> DATA.
  - DATA: on tick:
    - If bit_idx==DATA_BITS-1: go to PARITY with tx<=parity_bit when parity_en=1; otherwise go to STOP with tx<=1 and stop_cnt<=0.
    - Else: shift, bit_idx++, tx<=next bit.
  - PARITY: on tick tx<=1, stop_cnt<=0 -> STOP.
  - STOP: on tick:
    - If two_stop & stop_cnt==0: stop_cnt<=1 and stay in STOP.
    - Else the frame ends and tx_done<=1 for exactly one cycle.
      - If tx_valid in the same cycle: accept, tx<=0, go directly to START. This gives back-to-back frames with no idle gap.
      - Else go to IDLE with tx_busy<=0.
- Parity: parity_bit = ^data for even parity, ~^data for odd parity. It is computed from the latched data.
- Frame length: 1 + DATA_BITS + parity_en + (1 + two_stop) tick periods. SYNC adds up to one period of latency before the start bit.
- tx_busy is 1 from the cycle after accept until the cycle after the frame ends (unless a back-to-back frame is accepted). tx_done and the frame-end transition occur in the same registered update.
- Reset mid-frame: tx returns to 1 on the next clock and the frame is abandoned. No tx_done is produced.
- A baud_rate change upstream mid-frame is not detected; bit widths follow the ticks as they arrive.

Test Plan:
- Bench drives baud_clk toggling every 4 clocks (period 8). Send 0x55 with parity_en=0, two_stop=0 -> tx sequence is 0,1,0,1,0,1,0,1,0,1. Each bit lasts exactly 8 clocks. tx_done pulses once for 1 cycle; tx_busy then drops and tx_ready=1.
- Send 0xA3 with even parity -> bits 0,1,1,0,0,0,1,0,1, parity 0, stop 1. Repeat with odd parity -> parity bit 1. Frame length is 11 periods (88 clocks).
- Send 0x07 with odd parity, two_stop=1 -> parity 0, then two stop bits of 8 clocks each. tx_done follows the second stop bit only.
- Hold tx_valid high with 0x12 then 0x34 -> second accept happens in the final stop-tick cycle. The start bit of 0x34 immediately follows the stop bit of 0x12 with no idle gap. tx_busy stays 1 throughout.
- Change tx_data, two_stop and parity inputs mid-frame, and pulse tx_valid while busy -> the transmitted frame is unaffected and no extra accept occurs.
- Assert reset during DATA bit 3 -> next cycle tx=1, tx_busy=0, tx_ready=1 and no tx_done. A subsequent 0xFF frame transmits correctly.
